taxi_stats_event_tx: RTL and testbench
======================================

Name: taxi_stats_event_tx

Overview:
- Statistics producer: the transmit end of the stat-increment stream consumed by the XFCP statistics module.
- Accumulates per-cycle event increments from CNT local sources in private counters.
- Emits those counts as AXI-stream increment records: tdata = increment, tid = global counter index.
- Sits beside any status-producing block (MAC, FIFO, PHY glue) and feeds a stats collector or mux.

Parameters:
- CNT, 8: number of event channels.
- INC_W, 1: width of each per-cycle increment input.
- DATA_W, 16: accumulator and tdata width. Must be > INC_W.
- ID_W, 10: tid width.
- ID_BASE, 0: tid of channel 0; channel i uses ID_BASE+i. Must fit in ID_W.
- UPDATE_PERIOD, 1024: cycles between forced sweeps. 0 disables sweeps.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- stat_inc  in  CNT*INC_W  per-channel increment, sampled every cycle; channel i is bits [i*INC_W +: INC_W].
- m_axis_stat.tdata  out  DATA_W  increment value.
- m_axis_stat.tid  out  ID_W  counter index.
- m_axis_stat.tuser  out  1  constant 0.
- m_axis_stat.tvalid  out  1  record valid.
- m_axis_stat.tready  in  1  sink ready.
- stat_overflow  out  CNT  one-cycle pulse per channel when an increment was lost to saturation.

Behaviour:
- Reset (rst_n low, async) clears all of the following; state is IDLE:
  - accumulators, timer, sweep_pending, scan index;
  - tvalid, tdata, tid, stat_overflow.
- Release is synchronous to clk.

Accumulate:
- Every cycle acc[i] <= acc[i] + stat_inc[i], saturating at 2^DATA_W-1.
- If the true sum exceeds the maximum, acc saturates and stat_overflow[i] pulses for that cycle.
- No increment is ever dropped except by saturation.

Capture:
- Loads tdata <= acc[i] and tid <= ID_BASE+i, and sets tvalid.
- In the same cycle acc[i] <= stat_inc[i] (clear-and-add), so a coincident increment is retained.
- A capture is only performed when the output register is empty (tvalid low), or empty next cycle (tvalid && tready).

Output handshake:
- tvalid stays high and tdata/tid stay stable until tvalid && tready.
- tvalid does not depend combinationally on tready.
- Back-to-back records are allowed: the transfer cycle may also capture the next record.

Urgent channel:
- acc[i] MSB set, i.e. acc >= 2^(DATA_W-1).
- Has priority over sweeps; lowest index wins.

Timer:
- Counts 0..UPDATE_PERIOD-1; on wrap sets sweep_pending.
- A wrap while a sweep is pending or active is absorbed; there is no queueing.

States:
- IDLE:
  - urgent channel present and output free -> capture lowest urgent, stay IDLE;
  - else if sweep_pending -> clear it, idx=0, go to SCAN.
- SCAN (one channel per cycle):
  - urgent channel present and output free -> capture urgent, idx unchanged;
  - else acc[idx] != 0 and output free -> capture idx, idx++;
  - else acc[idx] == 0 -> idx++;
  - else (output busy, acc[idx] != 0) -> hold idx.
  - After idx == CNT-1 is handled -> IDLE.
- Zero-valued records are never emitted.

Latency:
- Urgent channel with the output free: record is valid 1 cycle after the increment that set the MSB.
- Sweep of N non-zero channels with tready=1: ends within CNT+1 cycles of the timer wrap.

Width rules:
- Increments are zero-extended to DATA_W.
- tid = ID_BASE + i, truncated to ID_W.

Test Plan:
- Reset mid-record (tvalid high, tready low), assert rst_n=0 -> tvalid=0 immediately (async); all acc read 0 at next sweep; no stale record appears.
- CNT=8, UPDATE_PERIOD=64; pulse channel 3 five times, tready=1 -> exactly one record per sweep with tdata=5, tid=3; no records for other channels; next sweep emits nothing.
- ID_BASE=16; channels 0, 2, 7 get 1, 2, 3 events; tready low for 10 cycles during the sweep -> records (1,16), (2,18), (3,23) in order, each held stable while stalled; no loss.
- DATA_W=8, INC_W=4, UPDATE_PERIOD=0; stat_inc[1]=15 every cycle -> record tid=1 with tdata in 128..142 (first capture after MSB set); subsequent records sum exactly to the injected total.
- Coincident capture: channel 2 increment on the capture cycle of channel 2 -> captured value excludes it; the next record for channel 2 includes it (sum preserved).
- Saturation: DATA_W=8, tready=0, inject 300 events on channel 0 -> tdata of the held record plus acc saturates; stat_overflow[0] pulses once per lost increment (sum of emitted + pulses = 300).

Source files
------------

// File: rtl/taxi_stats_event_tx.sv
// Statistics event transmitter: per-channel saturating accumulators drained as
// AXI-stream increment records, either urgently (MSB set) or by periodic sweep.
module taxi_stats_event_tx #(
  parameter int unsigned CNT           = 8,
  parameter int unsigned INC_W         = 1,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ID_W          = 10,
  parameter int unsigned ID_BASE       = 0,
  parameter int unsigned UPDATE_PERIOD = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT*INC_W-1:0] stat_inc,
  output logic [DATA_W-1:0]    m_axis_stat_tdata,
  output logic [ID_W-1:0]      m_axis_stat_tid,
  output logic                 m_axis_stat_tuser,
  output logic                 m_axis_stat_tvalid,
  input  logic                 m_axis_stat_tready,
  output logic [CNT-1:0]       stat_overflow
);

  localparam int unsigned IDX_W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int unsigned TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int unsigned SUM_W = DATA_W + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] acc      [CNT];
  logic [DATA_W-1:0] acc_next [CNT];
  logic [SUM_W-1:0]  sum      [CNT];
  logic [CNT-1:0]    ovf;
  logic [TMR_W-1:0]  timer;
  logic              wrap;
  logic              sweep_pending;
  logic [IDX_W-1:0]  idx;
  logic              idx_zero, idx_last;
  logic              out_free;
  logic              urg_any;
  logic [IDX_W-1:0]  urg_idx;
  logic              cap_en, adv, start;
  logic [IDX_W-1:0]  cap_idx;

  assign m_axis_stat_tuser = 1'b0;
  assign out_free = !m_axis_stat_tvalid || m_axis_stat_tready;
  assign idx_zero = (acc[idx] == '0);
  assign idx_last = (idx == IDX_W'(CNT - 1));
  assign wrap     = (UPDATE_PERIOD != 0) && (timer == TMR_W'(UPDATE_PERIOD - 1));

  // Lowest-index channel whose accumulator has reached half scale
  always_comb begin
    urg_any = 1'b0;
    urg_idx = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (acc[i][DATA_W-1]) begin
        urg_any = 1'b1;
        urg_idx = IDX_W'(i);
      end
    end
  end

  // Saturating add; a captured channel restarts from the coincident increment
  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      sum[i] = SUM_W'(stat_inc[i*INC_W +: INC_W]);
      if (!(cap_en && cap_idx == IDX_W'(i)))
        sum[i] = sum[i] + SUM_W'(acc[i]);
      ovf[i]      = sum[i][DATA_W];
      acc_next[i] = ovf[i] ? '1 : sum[i][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!(urg_any && out_free) && sweep_pending) state_next = SCAN;
      SCAN: if (!(urg_any && out_free) && (idx_zero || out_free) && idx_last)
              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cap_en  = 1'b0;
    cap_idx = '0;
    adv     = 1'b0;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (urg_any && out_free) begin
          cap_en  = 1'b1;
          cap_idx = urg_idx;
        end else if (sweep_pending) begin
          start = 1'b1;
        end
      end
      SCAN: begin
        if (urg_any && out_free) begin
          cap_en  = 1'b1;
          cap_idx = urg_idx;
        end else if (!idx_zero && out_free) begin
          cap_en  = 1'b1;
          cap_idx = idx;
          adv     = 1'b1;
        end else if (idx_zero) begin
          adv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sweep timer; wraps during a pending or active sweep are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer         <= '0;
      sweep_pending <= 1'b0;
    end else begin
      if (wrap)                     timer <= '0;
      else if (UPDATE_PERIOD != 0)  timer <= timer + TMR_W'(1);
      if (start)                                      sweep_pending <= 1'b0;
      else if (wrap && state == IDLE && !sweep_pending) sweep_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CNT; i++) acc[i] <= '0;
      idx                <= '0;
      m_axis_stat_tvalid <= 1'b0;
      m_axis_stat_tdata  <= '0;
      m_axis_stat_tid    <= '0;
      stat_overflow      <= '0;
    end else begin
      for (int i = 0; i < CNT; i++) acc[i] <= acc_next[i];
      stat_overflow <= ovf;
      if (start)    idx <= '0;
      else if (adv) idx <= idx_last ? '0 : idx + IDX_W'(1);
      if (cap_en) begin
        m_axis_stat_tvalid <= 1'b1;
        m_axis_stat_tdata  <= acc[cap_idx];
        m_axis_stat_tid    <= ID_W'(ID_BASE) + ID_W'(cap_idx);
      end else if (m_axis_stat_tready) begin
        m_axis_stat_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_taxi_stats_event_tx.sv
// Directed bench: sweep-driven records (A) and urgent/saturation behaviour (B).
module tb_taxi_stats_event_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  inc_a;
  logic [15:0] tdata_a;
  logic [9:0]  tid_a;
  logic        tuser_a, tvalid_a, tready_a;
  logic [7:0]  ovf_a;
  logic [15:0] inc_b;
  logic [7:0]  tdata_b;
  logic [9:0]  tid_b;
  logic        tuser_b, tvalid_b, tready_b;
  logic [3:0]  ovf_b;

  taxi_stats_event_tx #(.CNT(8), .INC_W(1), .DATA_W(16), .ID_W(10), .ID_BASE(16),
                        .UPDATE_PERIOD(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .stat_inc(inc_a),
    .m_axis_stat_tdata(tdata_a), .m_axis_stat_tid(tid_a), .m_axis_stat_tuser(tuser_a),
    .m_axis_stat_tvalid(tvalid_a), .m_axis_stat_tready(tready_a), .stat_overflow(ovf_a));

  taxi_stats_event_tx #(.CNT(4), .INC_W(4), .DATA_W(8), .ID_W(10), .ID_BASE(0),
                        .UPDATE_PERIOD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .stat_inc(inc_b),
    .m_axis_stat_tdata(tdata_b), .m_axis_stat_tid(tid_b), .m_axis_stat_tuser(tuser_b),
    .m_axis_stat_tvalid(tvalid_b), .m_axis_stat_tready(tready_b), .stat_overflow(ovf_b));

  int checks, errors;
  int cyc;
  int qa_d[$], qa_i[$], qb_d[$], qb_i[$];
  int ovf_b0_cnt;
  logic        pv_a, pv_b;
  logic [15:0] pd_a;
  logic [7:0]  pd_b;
  logic [9:0]  pi_a, pi_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record capture and stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_a = 1'b0;
      pv_b = 1'b0;
    end else begin
      if (pv_a) begin
        chk("hold_valid_a", 32'(tvalid_a), 32'd1);
        chk("hold_data_a", 32'(tdata_a), 32'(pd_a));
        chk("hold_id_a", 32'(tid_a), 32'(pi_a));
      end
      if (pv_b) begin
        chk("hold_valid_b", 32'(tvalid_b), 32'd1);
        chk("hold_data_b", 32'(tdata_b), 32'(pd_b));
      end
      if (tvalid_a && tready_a) begin qa_d.push_back(int'(tdata_a)); qa_i.push_back(int'(tid_a)); end
      if (tvalid_b && tready_b) begin qb_d.push_back(int'(tdata_b)); qb_i.push_back(int'(tid_b)); end
      if (ovf_b[0]) ovf_b0_cnt++;
      pv_a = tvalid_a && !tready_a; pd_a = tdata_a; pi_a = tid_a;
      pv_b = tvalid_b && !tready_b; pd_b = tdata_b; pi_b = tid_b;
    end
  end

  int exp_d[3] = '{1, 2, 3};
  int exp_i[3] = '{16, 18, 23};

  initial begin
    checks = 0; errors = 0; ovf_b0_cnt = 0;
    rst_n = 1'b0; inc_a = '0; inc_b = '0; tready_a = 1'b1; tready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tvalid_a", 32'(tvalid_a), 32'd0);
    chk("rst_tdata_a", 32'(tdata_a), 32'd0);
    chk("rst_tid_a", 32'(tid_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_tuser_a", 32'(tuser_a), 32'd0);
    chk("rst_tvalid_b", 32'(tvalid_b), 32'd0);

    // Five events on channel 3: one record at the first sweep, none at the second
    repeat (5) begin inc_a = 8'h08; step(); end
    inc_a = '0;
    wait_cyc(140);
    chk("single_count", 32'(qa_d.size()), 32'd1);
    if (qa_d.size() > 0) begin
      chk("single_data", 32'(qa_d[0]), 32'd5);
      chk("single_id", 32'(qa_i[0]), 32'd19);
    end
    qa_d.delete(); qa_i.delete();

    // Channels 0/2/7 get 1/2/3 events; sweep runs into a stalled sink
    tready_a = 1'b0;
    inc_a = 8'b1000_0101; step();
    inc_a = 8'b1000_0100; step();
    inc_a = 8'b1000_0000; step();
    inc_a = '0;
    wait_cyc(205);
    chk("stall_valid", 32'(tvalid_a), 32'd1);
    chk("stall_data", 32'(tdata_a), 32'd1);
    tready_a = 1'b1;
    wait_cyc(240);
    chk("order_count", 32'(qa_d.size()), 32'd3);
    for (int k = 0; k < 3 && k < qa_d.size(); k++) begin
      chk("order_data", 32'(qa_d[k]), 32'(exp_d[k]));
      chk("order_id", 32'(qa_i[k]), 32'(exp_i[k]));
    end
    qa_d.delete(); qa_i.delete();

    // Async reset while a record is held
    tready_a = 1'b0;
    inc_a = 8'h60; repeat (2) step();
    inc_a = 8'h20; repeat (2) step();
    inc_a = '0;
    wait_cyc(270);
    chk("pre_rst_valid", 32'(tvalid_a), 32'd1);
    chk("pre_rst_data", 32'(tdata_a), 32'd4);
    chk("pre_rst_id", 32'(tid_a), 32'd21);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(tvalid_a), 32'd0);
    chk("async_rst_data", 32'(tdata_a), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; tready_a = 1'b1;
    qa_d.delete(); qa_i.delete();
    step();
    wait_cyc(140);
    chk("post_rst_records", 32'(qa_d.size()), 32'd0);

    // Urgent capture with coincident increment retained (15 per cycle, 20 cycles)
    qb_d.delete(); qb_i.delete();
    inc_b = 16'h00F0; repeat (20) step();
    inc_b = '0; repeat (5) step();
    chk("urg_count", 32'(qb_d.size()), 32'd2);
    if (qb_d.size() >= 2) begin
      chk("urg_data0", 32'(qb_d[0]), 32'd135);
      chk("urg_id0", 32'(qb_i[0]), 32'd1);
      chk("urg_data1", 32'(qb_d[1]), 32'd135);
      chk("urg_id1", 32'(qb_i[1]), 32'd1);
    end

    // Saturation: record held on channel 2, then 300 single events on channel 0
    qb_d.delete(); qb_i.delete();
    tready_b = 1'b0;
    inc_b = 16'h0F00; repeat (9) step();
    ovf_b0_cnt = 0;
    inc_b = 16'h0001; repeat (300) step();
    inc_b = '0; repeat (3) step();
    chk("sat_held_valid", 32'(tvalid_b), 32'd1);
    chk("sat_held_data", 32'(tdata_b), 32'd135);
    chk("sat_held_id", 32'(tid_b), 32'd2);
    chk("sat_ovf_pulses", 32'(ovf_b0_cnt), 32'd45);
    tready_b = 1'b1;
    repeat (5) step();
    chk("sat_count", 32'(qb_d.size()), 32'd2);
    if (qb_d.size() >= 2) begin
      chk("sat_data0", 32'(qb_d[0]), 32'd135);
      chk("sat_id0", 32'(qb_i[0]), 32'd2);
      chk("sat_data1", 32'(qb_d[1]), 32'd255);
      chk("sat_id1", 32'(qb_i[1]), 32'd0);
      chk("sat_total", 32'(qb_d[1] + ovf_b0_cnt), 32'd300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
